// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream packer types and constants
package axis_pkg;

    localparam int AXIS_BYTE_WIDTH = 8;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// rtl/axis_pipe_reg.sv - single-entry valid/ready register slice
module axis_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // The slot can take a new entry when empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/axis_byte_packer.sv
// rtl/axis_byte_packer.sv - packs a byte stream into wide words; AXIS_BYTE_PACKER_TUSER_EN forwards tuser
module axis_byte_packer
    import axis_pkg::*;
#(
    parameter int OUTPUT_KEEP_WIDTH = 8,
    localparam int OUTPUT_DATA_WIDTH = AXIS_BYTE_WIDTH * OUTPUT_KEEP_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_BYTE_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    output logic [OUTPUT_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [OUTPUT_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser
);

    localparam int CW = $clog2(OUTPUT_KEEP_WIDTH + 1);
`ifdef AXIS_BYTE_PACKER_TUSER_EN
    localparam int PW = OUTPUT_DATA_WIDTH + OUTPUT_KEEP_WIDTH + 2;
`else
    localparam int PW = OUTPUT_DATA_WIDTH + OUTPUT_KEEP_WIDTH + 1;
`endif

    state_t                 state;
    logic [CW-1:0]          byte_count;
    logic [CW-1:0]          hold_count;
    logic [OUTPUT_DATA_WIDTH-1:0] acc_data;
    logic                   hold_last;

    logic [OUTPUT_DATA_WIDTH-1:0] cand_data;
    logic [CW-1:0]          cand_count;
    logic                   accept;
    logic                   complete;
    logic                   push;
    logic                   slot_free;
    logic [OUTPUT_DATA_WIDTH-1:0] word_data;
    logic [CW-1:0]          word_count;
    logic [OUTPUT_KEEP_WIDTH-1:0] word_keep;
    logic                   word_last;
    logic [PW-1:0]          pipe_in;
    logic [PW-1:0]          pipe_out;

    always_comb begin
        cand_data = acc_data;
        for (int i = 0; i < OUTPUT_KEEP_WIDTH; i++) begin
            if (s_axis_tkeep && byte_count == CW'(i)) begin
                cand_data[i*AXIS_BYTE_WIDTH +: AXIS_BYTE_WIDTH] = s_axis_tdata;
            end
        end
        cand_count = byte_count + CW'(s_axis_tkeep);
        accept     = s_axis_tvalid && s_axis_tready;
        complete   = accept && (s_axis_tlast ||
                     (s_axis_tkeep && byte_count == CW'(OUTPUT_KEEP_WIDTH - 1)));
        // In HOLD the completed word lives in the accumulator registers.
        push       = (state == HOLD) || complete;
        word_data  = (state == HOLD) ? acc_data   : cand_data;
        word_count = (state == HOLD) ? hold_count : cand_count;
        word_last  = (state == HOLD) ? hold_last  : s_axis_tlast;
        word_keep  = '0;
        for (int i = 0; i < OUTPUT_KEEP_WIDTH; i++) begin
            word_keep[i] = CW'(i) < word_count;
        end
    end

`ifdef AXIS_BYTE_PACKER_TUSER_EN
    logic hold_user;
    logic word_user;

    assign word_user = (state == HOLD) ? hold_user : (s_axis_tuser && s_axis_tlast);
    assign pipe_in   = {word_user, word_last, word_keep, word_data};
    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = pipe_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_user <= 1'b0;
        end else if (state == ACCUM && complete && !slot_free) begin
            hold_user <= s_axis_tuser && s_axis_tlast;
        end
    end
`else
    logic unused_tuser;

    assign unused_tuser = s_axis_tuser;
    assign pipe_in      = {word_last, word_keep, word_data};
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = pipe_out;
    assign m_axis_tuser = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACCUM;
            byte_count    <= '0;
            hold_count    <= '0;
            acc_data      <= '0;
            hold_last     <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    s_axis_tready <= 1'b1;
                    if (complete) begin
                        byte_count <= '0;
                        if (slot_free) begin
                            acc_data <= '0;
                        end else begin
                            acc_data      <= cand_data;
                            hold_count    <= cand_count;
                            hold_last     <= s_axis_tlast;
                            state         <= HOLD;
                            s_axis_tready <= 1'b0;
                        end
                    end else if (accept && s_axis_tkeep) begin
                        acc_data   <= cand_data;
                        byte_count <= cand_count;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        acc_data      <= '0;
                        byte_count    <= '0;
                        state         <= ACCUM;
                        s_axis_tready <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    axis_pipe_reg #(
        .WIDTH(PW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_data  (pipe_in),
        .in_valid (push),
        .in_ready (slot_free),
        .out_data (pipe_out),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

endmodule

// File: tb/tb_axis_byte_packer.sv
// tb/tb_axis_byte_packer.sv - scoreboard bench for axis_byte_packer
module tb_axis_byte_packer;

    localparam int N = 8;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tkeep = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc_cyc = 0;
    exp_t q[$];

`ifdef AXIS_BYTE_PACKER_TUSER_EN
    localparam logic USER_ON = 1'b1;
`else
    localparam logic USER_ON = 1'b0;
`endif

    axis_byte_packer #(.OUTPUT_KEEP_WIDTH(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic k, input logic l, input logic u);
        int t = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", d);
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic expect_word(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input logic u, input int c);
        exp_t e;
        e.data = d; e.keep = k; e.last = l; e.user = u; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: every handshake on m_axis pops one expected word.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h, none expected", m_tdata, m_tkeep);
            end else begin
                e = q.pop_front();
                if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last ||
                    m_tuser !== e.user || (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL word: got data 0x%0h keep 0x%0h last %0b user %0b cyc %0d expected data 0x%0h keep 0x%0h last %0b user %0b cyc %0d",
                             m_tdata, m_tkeep, m_tlast, m_tuser, cyc, e.data, e.keep, e.last, e.user, e.cyc);
                end
            end
        end
    end

    initial begin
        int start;
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_s_tready", 64'(s_tready), 64'd0);
        chk("reset_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("reset_m_tdata", m_tdata, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_reset", 64'(s_tready), 64'd1);

        // Two full words, one-cycle latency and no bubbles.
        start = cyc;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b1, i == 15, 1'b0);
            if (i == 7)  expect_word(64'h0706050403020100, 8'hFF, 1'b0, 1'b0, last_acc_cyc);
            if (i == 15) expect_word(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 1'b0, last_acc_cyc);
        end
        chk("no_bubbles", 64'(last_acc_cyc - start), 64'd16);

        // Short frame.
        send_byte(8'hA1, 1'b1, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b1, 1'b0, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b1, 1'b0);
        expect_word(64'h0000000000A3A2A1, 8'h07, 1'b1, 1'b0, last_acc_cyc);

        // Null bytes, then a lone null tlast.
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(8'hEE, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0, 1'b0);
        send_byte(8'hEE, 1'b0, 1'b1, 1'b0);
        expect_word(64'h2211, 8'h03, 1'b1, 1'b0, last_acc_cyc);
        send_byte(8'hEE, 1'b0, 1'b1, 1'b0);
        expect_word(64'h0, 8'h00, 1'b1, 1'b0, last_acc_cyc);

        // Backpressure: slot full after word 1, HOLD after word 2.
        @(posedge clk); #1;
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
            if (i == 14) chk("tready_before_16th", 64'(s_tready), 64'd1);
        end
        chk("tready_after_16th", 64'(s_tready), 64'd0);
        expect_word(64'h3736353433323130, 8'hFF, 1'b0, 1'b0, -1);
        expect_word(64'h3F3E3D3C3B3A3938, 8'hFF, 1'b0, 1'b0, -1);
        fork
            begin
                for (int i = 16; i < 24; i++) send_byte(8'(8'h30 + i), 1'b1, i == 23, 1'b0);
                expect_word(64'h4746454443424140, 8'hFF, 1'b1, 1'b0, -1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join

        // Reset mid-frame discards the partial word.
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
        expect_word(64'h5756555453525150, 8'hFF, 1'b0, 1'b0, last_acc_cyc);

        // tuser on the tlast byte of a 10-byte frame.
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'h60 + i), 1'b1, i == 9, i == 9);
            if (i == 7) expect_word(64'h6766656463626160, 8'hFF, 1'b0, 1'b0, last_acc_cyc);
        end
        expect_word(64'h6968, 8'h03, 1'b1, USER_ON, last_acc_cyc);

        t = 0;
        while (q.size() != 0 && t < 1000) begin
            t++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule
